// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter that shares the single write port
//               (rw/dw/rwe) of a 4x4-bit register file between two bursting
//               requesters, A and B. A requester keeps the port for a burst.
//               A burst ends on its last beat, on reaching MAX_BURST beats,
//               or when its request drops. Ties go to the requester that did
//               not own the port most recently. After reset, A wins the
//               first tie.
//
// Parameters  : DATA_W    - register data width
//               ADDR_W    - register address width
//               MAX_BURST - beats per grant before a forced hand-over (1..15)
//
// Ports       : clk                          - system clock, rising edge
//               rst                          - synchronous reset, active-high
//               a_req/a_addr/a_data/a_last   - requester A write beat
//               a_gnt                        - A owns the write port
//               b_req/b_addr/b_data/b_last   - requester B write beat
//               b_gnt                        - B owns the write port
//               rw/dw/rwe                    - registered register-file write port
//               err_r0                       - sticky flag: a write to r0 was dropped
//
// Options     : REGFILE_ARB_R0_PROTECT_EN
//                   When defined, accepted beats that address r0 are still
//                   acknowledged and counted. The write enable stays low, so
//                   r0 is not written, and err_r0 sets.
//                   When undefined, r0 is written like any other register,
//                   and err_r0 is tied low.
//
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_gnt,
    output logic [ADDR_W-1:0] rw,
    output logic [DATA_W-1:0] dw,
    output logic              rwe,
    output logic              err_r0
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_OWN_A = 2'd1;
    localparam logic [1:0] c_ST_OWN_B = 2'd2;

    // Round-robin pointer values: the requester that wins the next tie
    localparam logic c_RR_A = 1'b0;
    localparam logic c_RR_B = 1'b1;

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_rr_next;
    logic              w_rr_next_nxt;
    logic [3:0]        r_beat_cnt;
    logic [3:0]        w_beat_cnt_nxt;

    logic [ADDR_W-1:0] r_rw;
    logic [DATA_W-1:0] r_dw;
    logic              r_rwe;

    // ------------------------------------------------------------------------
    // Owner-relative view of the requesters
    // ------------------------------------------------------------------------
    logic              w_own_a;
    logic              w_own_b;
    logic              w_owner_req;
    logic              w_owner_last;
    logic [ADDR_W-1:0] w_owner_addr;
    logic [DATA_W-1:0] w_owner_data;
    logic              w_other_req;
    logic              w_accept;
    logic              w_cap_hit;
    logic              w_burst_end;

    assign w_own_a = (r_state == c_ST_OWN_A);
    assign w_own_b = (r_state == c_ST_OWN_B);

    // Grants come straight from the state register, so no request input
    // has a combinational path to a grant output.
    assign a_gnt = w_own_a;
    assign b_gnt = w_own_b;

    assign w_owner_req  = w_own_a ? a_req  : (w_own_b ? b_req : 1'b0);
    assign w_owner_last = w_own_a ? a_last : b_last;
    assign w_owner_addr = w_own_a ? a_addr : b_addr;
    assign w_owner_data = w_own_a ? a_data : b_data;
    assign w_other_req  = w_own_a ? b_req  : a_req;

    assign w_accept = w_owner_req;

    // The beat being accepted now brings the count up to the cap.
    // MAX_BURST is at most 15, so the 4-bit counter never wraps.
    assign w_cap_hit = ((r_beat_cnt + 4'd1) == c_MAX_BURST);

    // The burst ends when the owner stops requesting, or when an accepted beat
    // is marked last or reaches the cap.
    assign w_burst_end = (w_own_a | w_own_b) &
                         (~w_owner_req | w_owner_last | w_cap_hit);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_next_nxt  = r_rr_next;
        w_beat_cnt_nxt = r_beat_cnt;

        case (r_state)
            c_ST_IDLE: begin
                if (a_req && b_req) begin
                    w_state_nxt = (r_rr_next == c_RR_B) ? c_ST_OWN_B : c_ST_OWN_A;
                end else if (a_req) begin
                    w_state_nxt = c_ST_OWN_A;
                end else if (b_req) begin
                    w_state_nxt = c_ST_OWN_B;
                end
            end

            c_ST_OWN_A, c_ST_OWN_B: begin
                if (w_burst_end) begin
                    w_rr_next_nxt  = w_own_a ? c_RR_B : c_RR_A;
                    w_beat_cnt_nxt = 4'd0;
                    if (w_other_req) begin
                        // Hand over directly, with no idle cycle in between.
                        w_state_nxt = w_own_a ? c_ST_OWN_B : c_ST_OWN_A;
                    end else if (w_owner_req) begin
                        // The burst was ended by last or the cap, but nobody
                        // else is waiting, so the same requester starts a
                        // fresh burst.
                        w_state_nxt = r_state;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_rr_next  <= c_RR_A;
            r_beat_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_next  <= w_rr_next_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------------
`ifdef REGFILE_ARB_R0_PROTECT_EN
    logic w_addr_is_r0;
    logic r_err_r0;

    assign w_addr_is_r0 = (w_owner_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw     <= '0;
            r_dw     <= '0;
            r_rwe    <= 1'b0;
            r_err_r0 <= 1'b0;
        end else if (w_accept) begin
            r_rw  <= w_owner_addr;
            r_dw  <= w_owner_data;
            // A beat to r0 is consumed like any other beat, but its write
            // enable is suppressed.
            r_rwe <= ~w_addr_is_r0;
            if (w_addr_is_r0) begin
                r_err_r0 <= 1'b1;
            end
        end else begin
            r_rwe <= 1'b0;
        end
    end

    assign err_r0 = r_err_r0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw  <= '0;
            r_dw  <= '0;
            r_rwe <= 1'b0;
        end else if (w_accept) begin
            r_rw  <= w_owner_addr;
            r_dw  <= w_owner_data;
            r_rwe <= 1'b1;
        end else begin
            r_rwe <= 1'b0;
        end
    end

    assign err_r0 = 1'b0;
`endif

    assign rw  = r_rw;
    assign dw  = r_dw;
    assign rwe = r_rwe;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
//               It includes a small 4x4 register-file model on the write
//               port, so committed register contents can be checked as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int c_DATA_W = 4;
    localparam int c_ADDR_W = 2;

    logic                clk;
    logic                rst;
    logic                a_req;
    logic [c_ADDR_W-1:0] a_addr;
    logic [c_DATA_W-1:0] a_data;
    logic                a_last;
    logic                a_gnt;
    logic                b_req;
    logic [c_ADDR_W-1:0] b_addr;
    logic [c_DATA_W-1:0] b_data;
    logic                b_last;
    logic                b_gnt;
    logic [c_ADDR_W-1:0] rw;
    logic [c_DATA_W-1:0] dw;
    logic                rwe;
    logic                err_r0;

    int checks;
    int errors;

    // Register file model, written on the edge after the arbiter registers a beat
    logic [c_DATA_W-1:0] rf [4];
    logic                rf_clr;

    regfile_write_arbiter #(
        .DATA_W   (c_DATA_W),
        .ADDR_W   (c_ADDR_W),
        .MAX_BURST(4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .a_req (a_req),
        .a_addr(a_addr),
        .a_data(a_data),
        .a_last(a_last),
        .a_gnt (a_gnt),
        .b_req (b_req),
        .b_addr(b_addr),
        .b_data(b_data),
        .b_last(b_last),
        .b_gnt (b_gnt),
        .rw    (rw),
        .dw    (dw),
        .rwe   (rwe),
        .err_r0(err_r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (rwe) begin
            rf[rw] <= dw;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle. Inputs changed after this are
    // sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_req = 1'b0;
        b_req = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rf_clr = 1'b1;
        rst    = 1'b1;
        a_req  = 1'b0; a_addr = '0; a_data = '0; a_last = 1'b0;
        b_req  = 1'b0; b_addr = '0; b_data = '0; b_last = 1'b0;

        // ---------------- Reset with both requesters active ----------------
        a_req = 1'b1; b_req = 1'b1;
        tick();
        rf_clr = 1'b0;
        tick();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_rwe",   rwe,   0);
        check("rst_rw",    rw,    0);
        check("rst_dw",    dw,    0);
        check("rst_err",   err_r0, 0);
        rst = 1'b0;
        tick();
        check("post_rst_a_gnt", a_gnt, 1);
        check("post_rst_b_gnt", b_gnt, 0);

        // ---------------- Single A write ----------------
        do_reset();
        a_req = 1'b1; a_addr = 2'd2; a_data = 4'b0101; a_last = 1'b1;
        tick();
        check("single_gnt", a_gnt, 1);
        check("single_rwe_pre", rwe, 0);
        tick();                              // beat accepted
        check("single_rwe", rwe, 1);
        check("single_rw",  rw,  2);
        check("single_dw",  dw,  4'b0101);
        a_req = 1'b0; a_last = 1'b0;
        tick();                              // register file commits here
        check("single_rwe_pulse", rwe, 0);
        check("single_rw_hold", rw, 2);
        check("single_idle", a_gnt, 0);
        check("single_rf2", rf[2], 4'b0101);

        // ---------------- Contention with burst cap ----------------
        do_reset();
        a_req = 1'b1; a_addr = 2'd1; a_last = 1'b0; a_data = 4'd1;
        b_req = 1'b1; b_addr = 2'd3; b_last = 1'b0; b_data = 4'd9;
        tick();
        check("cont_first_a", a_gnt, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();                          // A accepts beat i
            check("cont_a_rwe", rwe, 1);
            check("cont_a_dw",  dw,  i);
            check("cont_a_gnt", a_gnt, (i < 4) ? 1 : 0);
            a_data = 4'(i + 1);
        end
        check("cont_b_gnt_no_bubble", b_gnt, 1);
        tick();                              // B beat 1
        check("cont_b1_dw", dw, 9);
        check("cont_b1_rw", rw, 3);
        b_data = 4'd10; b_last = 1'b1;
        tick();                              // B last beat
        check("cont_b2_dw", dw, 10);
        check("cont_a_resume_gnt", a_gnt, 1);
        b_req = 1'b0; b_last = 1'b0;
        tick();                              // A beat 5
        check("cont_a5_dw", dw, 5);
        check("cont_a5_rwe", rwe, 1);
        a_data = 4'd6; a_last = 1'b1;
        tick();                              // A beat 6
        check("cont_a6_dw", dw, 6);
        a_req = 1'b0; a_last = 1'b0;
        tick();
        check("cont_end_rwe", rwe, 0);
        check("cont_end_gnt", a_gnt, 0);
        check("cont_rf1", rf[1], 6);
        check("cont_rf3", rf[3], 10);

        // ---------------- Tie alternation ----------------
        do_reset();
        a_req = 1'b1; a_addr = 2'd2; a_data = 4'd7; a_last = 1'b1;
        b_req = 1'b1; b_addr = 2'd1; b_data = 4'd8; b_last = 1'b1;
        tick();
        check("tie_first_a", a_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tie_rwe", rwe, 1);
            check("tie_dw", dw, (i % 2 == 0) ? 7 : 8);
            check("tie_rw", rw, (i % 2 == 0) ? 2 : 1);
            check("tie_next_a", a_gnt, (i % 2 == 0) ? 0 : 1);
            check("tie_next_b", b_gnt, (i % 2 == 0) ? 1 : 0);
        end
        a_req = 1'b0; b_req = 1'b0; a_last = 1'b0; b_last = 1'b0;
        tick();

        // ---------------- Reset mid-burst ----------------
        do_reset();
        a_req = 1'b1; a_addr = 2'd3; a_data = 4'd1; a_last = 1'b0;
        tick();
        tick();                              // beat 1 accepted
        check("midrst_b1_rwe", rwe, 1);
        a_data = 4'd2;
        rst = 1'b1;                          // reset lands on beat 2's edge
        tick();
        check("midrst_rwe", rwe, 0);
        check("midrst_gnt", a_gnt, 0);
        rst = 1'b0; a_req = 1'b0;
        tick();
        tick();
        check("midrst_rf3", rf[3], 1);

        // ---------------- B writes r0 ----------------
        do_reset();
        b_req = 1'b1; b_addr = 2'd0; b_data = 4'b1111; b_last = 1'b1;
        tick();
        check("r0_b_gnt", b_gnt, 1);
        tick();                              // beat accepted
        b_req = 1'b0; b_last = 1'b0;
`ifdef REGFILE_ARB_R0_PROTECT_EN
        check("r0_rwe", rwe, 0);
        check("r0_err", err_r0, 1);
        tick();
        tick();
        check("r0_rf0", rf[0], 0);
        check("r0_err_sticky", err_r0, 1);
`else
        check("r0_rwe", rwe, 1);
        check("r0_dw", dw, 4'b1111);
        check("r0_err", err_r0, 0);
        tick();
        tick();
        check("r0_rf0", rf[0], 4'b1111);
        check("r0_err_low", err_r0, 0);
`endif
        check("r0_idle", b_gnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
